// File: rtl/spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// spm_seq_ctrl
//
// Sequencing front/back end for a serial-parallel multiplier array of
// carry-save cells. An operand pair is accepted over a valid/ready handshake.
// The multiplier is presented in parallel on x. The multiplicand is serialised
// LSB first on y. The serial product stream p from the array is collected into
// a 2*WIDTH product, which is then offered on an output handshake.
//
// The controller performs no arithmetic. It only orders the bits and times
// their capture.
//
// Build option:
//   SPM_SEQ_CTRL_SIGNED_EN  When defined, y carries the multiplicand sign bit
//                           during the upper WIDTH shift cycles. The array then
//                           yields a two's-complement product. When undefined,
//                           y is zero-extended and the product is unsigned.
//
// Parameters:
//   WIDTH   operand width; the product is 2*WIDTH bits
//   P_LAT   cycles from the first y bit to the first valid p bit (>= 1)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   controller accepts operands (IDLE only)
//   a_in       multiplier, latched onto x at accept
//   b_in       multiplicand, serialised onto y
//   x          parallel multiplier to the array
//   y          serial multiplicand bit to the array
//   spm_rst    synchronous clear of the array sum/carry flops
//   p          serial product bit from the array
//   out_valid  product valid
//   out_ready  consumer accepts product
//   prod       collected 2*WIDTH product
// -----------------------------------------------------------------------------
module spm_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned P_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     x,
  output logic                 y,
  output logic                 spm_rst,
  input  logic                 p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned PW        = 2 * WIDTH;
  localparam int unsigned SHIFT_LEN = PW + P_LAT;
  // Sized to hold SHIFT_LEN itself, so the post-increment never wraps.
  localparam int unsigned CNT_W     = $clog2(SHIFT_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_W_HI = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_PW   = CNT_W'(PW);
  localparam logic [CNT_W-1:0] CNT_PLAT = CNT_W'(P_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StShift,
    StDone
  } state_e;

  // State registers.
  state_e            r_state;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_bsr;
  logic [CNT_W-1:0]  r_cnt;
  logic [PW-1:0]     r_psr;
  logic [PW-1:0]     r_prod;

  // Next-state values.
  state_e            w_state_d;
  logic [WIDTH-1:0]  w_x_d;
  logic [WIDTH-1:0]  w_bsr_d;
  logic [CNT_W-1:0]  w_cnt_d;
  logic [PW-1:0]     w_psr_d;
  logic [PW-1:0]     w_prod_d;

  logic              w_y;
  logic              w_clear;
  logic              w_ext;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
  // The multiplicand sign is kept apart from bsr because bsr has shifted it
  // out by the time the extension window starts.
  logic r_sign;
  logic w_sign_d;

  assign w_ext = r_sign;
`else
  assign w_ext = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_bsr_d   = r_bsr;
    w_cnt_d   = r_cnt;
    w_psr_d   = r_psr;
    w_prod_d  = r_prod;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
    w_sign_d  = r_sign;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_y       = 1'b0;
    w_clear   = 1'b0;

    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_x_d     = a_in;
          w_bsr_d   = b_in;
          w_cnt_d   = '0;
          w_psr_d   = '0;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
          w_sign_d  = b_in[WIDTH-1];
`endif
          w_state_d = StClear;
        end
      end

      StClear: begin
        // One cycle that flushes the array before the first y bit.
        w_clear   = 1'b1;
        w_state_d = StShift;
      end

      StShift: begin
        if (r_cnt < CNT_W_HI) begin
          w_y = r_bsr[0];
        end else if (r_cnt < CNT_PW) begin
          w_y = w_ext;
        end
        w_bsr_d = r_bsr >> 1;

        // The first P_LAT cycles carry array pipeline fill, not product bits.
        if (r_cnt >= CNT_PLAT) begin
          w_psr_d = {p, r_psr[PW-1:1]};
        end
        w_cnt_d = r_cnt + CNT_ONE;

        // P_LAT >= 1 guarantees the last cycle is also a capture cycle.
        if (r_cnt == CNT_LAST) begin
          w_prod_d  = w_psr_d;
          w_state_d = StDone;
        end
      end

      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_x     <= '0;
      r_bsr   <= '0;
      r_cnt   <= '0;
      r_psr   <= '0;
      r_prod  <= '0;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
      r_sign  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_x     <= w_x_d;
      r_bsr   <= w_bsr_d;
      r_cnt   <= w_cnt_d;
      r_psr   <= w_psr_d;
      r_prod  <= w_prod_d;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
      r_sign  <= w_sign_d;
`endif
    end
  end

  assign x       = r_x;
  assign y       = w_y;
  assign prod    = r_prod;
  // The array is cleared during reset as well as in CLEAR.
  assign spm_rst = rst | w_clear;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spm_seq_ctrl
//
// Bench for spm_seq_ctrl with WIDTH=8 and P_LAT=1.
//
// A behavioural stand-in for the multiplier array is built into the bench.
// The array is cleared by spm_rst. It collects the y bits it receives. It
// answers with product bit (k - P_LAT) of ext(x) * {y bits so far}, where k is
// the number of y bits seen. This matches an array with P_LAT cycles of
// latency. Outside the product window, p is driven with random noise.
//
// Expected products come from plain arithmetic on the operands. Build with
// SPM_SEQ_CTRL_SIGNED_EN to check the signed build.
// -----------------------------------------------------------------------------
module tb_spm_seq_ctrl;

  localparam int unsigned W     = 8;
  localparam int unsigned P_LAT = 1;
  localparam int unsigned PW    = 2 * W;
  localparam int          LAT   = 2 * W + P_LAT + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [W-1:0]  x;
  logic          y;
  logic          spm_rst;
  logic          p;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] prod;

  int n_cmp  = 0;
  int n_fail = 0;
  time last_acc;

  spm_seq_ctrl #(
    .WIDTH (W),
    .P_LAT (P_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .x         (x),
    .y         (y),
    .spm_rst   (spm_rst),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  // ---------------- array stand-in ----------------
  logic [PW-1:0] m_y;
  logic [PW-1:0] m_xe;
  logic [PW-1:0] m_prod;
  int            m_k;
  logic          m_noise;

  always @(posedge clk) begin
    if (spm_rst) begin
      m_k <= 0;
      m_y <= '0;
    end else begin
      if (m_k < PW) m_y[m_k] <= y;
      if (m_k < 1000) m_k <= m_k + 1;
    end
  end

  always @(negedge clk) m_noise <= 1'($urandom);

`ifdef SPM_SEQ_CTRL_SIGNED_EN
  assign m_xe = {{W{x[W-1]}}, x};
`else
  assign m_xe = {{W{1'b0}}, x};
`endif

  always_comb begin
    m_prod = m_xe * m_y;
    if (m_k >= P_LAT && (m_k - P_LAT) < PW) p = m_prod[m_k-P_LAT];
    else                                     p = m_noise;
  end

  // ---------------- reference and helpers ----------------
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] ae;
    logic [PW-1:0] be;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
`else
    ae = {{W{1'b0}}, a};
    be = {{W{1'b0}}, b};
`endif
    return ae * be;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation starting at a negedge. out_ready is held low for
  // 'hold' cycles after out_valid. With 'stray', spurious in_valid pulses are
  // driven while the controller is busy. The task returns at the negedge
  // after the output handshake.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                       input bit stray, output logic [PW-1:0] got);
    int lat;
    int w;
    logic [PW-1:0] exp;
    exp = ref_mul(a, b);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready before accept", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = (hold == 0);
    @(posedge clk);
    last_acc = $time;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
      end
      if (stray && lat == 6) in_valid = 1'b1;
      if (stray && lat == 7) in_valid = 1'b0;
      if (lat == 10) begin
        check("busy in_ready", 64'(in_ready), 64'd0);
        check("busy out_valid", 64'(out_valid), 64'd0);
      end
    end while (!out_valid && lat < 100);
    check("latency", 64'(lat), 64'(LAT));
    check("prod", 64'(prod), 64'(exp));
    check("x latched", 64'(x), 64'(a));
    for (int i = 0; i < hold; i++) begin
      if (stray && i == 2) begin
        in_valid = 1'b1;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
      end
      @(negedge clk);
      check("held prod", 64'(prod), 64'(exp));
      check("held in_ready", 64'(in_ready), 64'd0);
      check("held out_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got = prod;
    @(negedge clk);
    check("post out_valid", 64'(out_valid), 64'd0);
    check("post in_ready", 64'(in_ready), 64'd1);
    check("x after done", 64'(x), 64'(a));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [PW-1:0] got;
    time t0;
    int  lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("spm_rst in reset", 64'(spm_rst), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst prod", 64'(prod), 64'd0);
    check("rst spm_rst", 64'(spm_rst), 64'd0);
    check("rst x", 64'(x), 64'd0);
    check("rst y", 64'(y), 64'd0);

    // Directed products.
    do_op(8'd13, 8'd11, 0, 1'b0, got);
    check("13*11", 64'(got), 64'd143);
    do_op(8'hFD, 8'h05, 0, 1'b0, got);
`ifdef SPM_SEQ_CTRL_SIGNED_EN
    check("-3*5", 64'(got), 64'hFFF1);
`else
    check("253*5", 64'(got), 64'h04F1);
`endif
    do_op(8'h80, 8'h80, 0, 1'b0, got);
    check("80*80", 64'(got), 64'h4000);

    // Backpressure with a stray in_valid while busy and while done.
    do_op(8'($urandom), 8'($urandom), 10, 1'b1, got);

    // Reset in the middle of SHIFT at cnt=5.
    in_valid = 1'b1;
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
    out_ready = 1'b1;
    @(posedge clk);
    lat = 0;
    repeat (7) begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort spm_rst", 64'(spm_rst), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort prod", 64'(prod), 64'd0);
    repeat (25) @(negedge clk);
    check("abort no late valid", 64'(out_valid), 64'd0);
    do_op(8'd255, 8'd255, 0, 1'b0, got);
`ifdef SPM_SEQ_CTRL_SIGNED_EN
    check("-1*-1", 64'(got), 64'h0001);
`else
    check("255*255", 64'(got), 64'hFE01);
`endif

    // Back-to-back, out_ready tied high: accepts every LAT+1 cycles.
    for (int i = 0; i < 4; i++) begin
      do_op(8'($urandom), 8'($urandom), 0, 1'b0, got);
      if (i > 0) check("b2b spacing", 64'((last_acc - t0) / 10), 64'(LAT + 1));
      t0 = last_acc;
    end

    // Random operations with random backpressure.
    for (int i = 0; i < 8; i++) begin
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
